// File: rtl/program_loader.sv
// program_loader: writes a length-prefixed little-endian byte image into program memory,
// holding the core in reset until the whole image has been written.
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 8
`endif
`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 32
`endif
module program_loader #(
    parameter int ADDRESS_WIDTH     = `ADDRESS_SIZE,
    parameter int INSTRUCTION_WIDTH = `INSTRUCTION_SIZE
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         start_i,
    input  logic                         byte_valid_i,
    input  logic [7:0]                   byte_data_i,
    output logic                         byte_ready_o,
    output logic                         pm_write_enable_o,
    output logic [ADDRESS_WIDTH-1:0]     pm_address_o,
    output logic [INSTRUCTION_WIDTH-1:0] pm_data_in_o,
    output logic                         core_reset_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         error_o
);
    localparam int B  = INSTRUCTION_WIDTH / 8;
    localparam int IW = B > 1 ? $clog2(B) : 1;
    // Largest legal word count; wide address spaces never reject a 16-bit count.
    localparam logic [16:0] MAX_N = ADDRESS_WIDTH < 16 ? 17'd1 << ADDRESS_WIDTH : 17'h1ffff;

    typedef enum logic [2:0] {IDLE, COUNT_LO, COUNT_HI, ASSEMBLE, WRITE, DONE, ERROR} state_t;

    state_t                         state_q, state_d;
    logic [15:0]                    count_q, count_d;
    logic [15:0]                    word_q, word_d;
    logic [IW-1:0]                  idx_q, idx_d;
    logic [ADDRESS_WIDTH-1:0]       addr_q, addr_d;
    logic [INSTRUCTION_WIDTH-1:0]   data_q, data_d;
    logic [15:0]                    n;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            count_q <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // byte_ready is high in every byte-consuming state, so byte_valid alone marks a transfer there.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        word_d  = word_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        n       = {byte_data_i, count_q[7:0]};
        case (state_q)
            IDLE, DONE, ERROR: if (start_i) begin
                state_d = COUNT_LO;
                word_d  = '0;
                idx_d   = '0;
                addr_d  = '0;
            end
            COUNT_LO: if (byte_valid_i) begin
                count_d[7:0] = byte_data_i;
                state_d      = COUNT_HI;
            end
            COUNT_HI: if (byte_valid_i) begin
                count_d = n;
                state_d = (n == '0 || {1'b0, n} > MAX_N) ? ERROR : ASSEMBLE;
            end
            ASSEMBLE: if (byte_valid_i) begin
                data_d[{idx_q, 3'b000} +: 8] = byte_data_i;
                idx_d   = idx_q + IW'(1);
                state_d = idx_q == IW'(B - 1) ? WRITE : ASSEMBLE;
            end
            WRITE: begin
                word_d  = word_q + 16'd1;
                addr_d  = addr_q + ADDRESS_WIDTH'(1);
                idx_d   = '0;
                state_d = word_q == count_q - 16'd1 ? DONE : ASSEMBLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_ready_o      = state_q inside {COUNT_LO, COUNT_HI, ASSEMBLE};
    assign pm_write_enable_o = state_q == WRITE;
    assign pm_address_o      = addr_q;
    assign pm_data_in_o      = data_q;
    assign core_reset_o      = state_q != DONE;
    assign busy_o            = state_q inside {COUNT_LO, COUNT_HI, ASSEMBLE, WRITE};
    assign done_o            = state_q == DONE;
    assign error_o           = state_q == ERROR;
endmodule
